// File: rtl/ptcalc_dispatch.sv
// Multi-channel front end for the HLS pT-calculator core: per-channel job collection,
// round-robin dispatch to one shared ap_ctrl_hs core, and channel-tagged result return.
//
// slot state  | meaning
// S_EMPTY     | no job held
// S_COLLECT   | pipeline word held, waiting for segments or window expiry
// S_READY     | job complete, waiting for the dispatcher
// S_INFLIGHT  | job handed to the core
//
// dispatch    | meaning
// D_IDLE      | core free, looking for a READY slot
// D_START     | core_start asserted until core_ready
// D_WAIT      | waiting for core_done or timeout
module ptcalc_dispatch #(
  parameter int NUM_CH  = 3,
  parameter int PL_W    = 32,
  parameter int SF_W    = 24,
  parameter int OUT_W   = 16,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int WINDOW  = 32,
  parameter int TIMEOUT = 128
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_CH*PL_W-1:0] pl_data,
  input  logic [NUM_CH-1:0]      pl_vld,
  input  logic [NUM_CH*SF_W-1:0] sf_inn_data,
  input  logic [NUM_CH*SF_W-1:0] sf_mid_data,
  input  logic [NUM_CH*SF_W-1:0] sf_out_data,
  input  logic [NUM_CH-1:0]      sf_inn_vld,
  input  logic [NUM_CH-1:0]      sf_mid_vld,
  input  logic [NUM_CH-1:0]      sf_out_vld,
  input  logic                   is_C_side,
  output logic                   core_start,
  output logic [PL_W-1:0]        core_pl,
  output logic [SF_W-1:0]        core_sf_inn,
  output logic [SF_W-1:0]        core_sf_mid,
  output logic [SF_W-1:0]        core_sf_out,
  output logic                   core_is_C_side,
  input  logic                   core_ready,
  input  logic                   core_done,
  input  logic [OUT_W-1:0]       core_result,
  input  logic                   core_result_vld,
  output logic [OUT_W-1:0]       ptcalc2mtc,
  output logic                   ptcalc2mtc_vld,
  output logic [CH_W-1:0]        ptcalc2mtc_ch,
  output logic [NUM_CH-1:0]      slot_busy,
  output logic                   err_overflow,
  output logic                   err_timeout
);

  localparam int WIN_CW = $clog2(WINDOW + 1);
  localparam int TO_CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_EMPTY, S_COLLECT, S_READY, S_INFLIGHT} slot_st_t;
  typedef enum logic [1:0] {D_IDLE, D_START, D_WAIT} disp_st_t;

  slot_st_t          slot_st [NUM_CH];
  logic [PL_W-1:0]   pl_q    [NUM_CH];
  logic [SF_W-1:0]   inn_q   [NUM_CH];
  logic [SF_W-1:0]   mid_q   [NUM_CH];
  logic [SF_W-1:0]   out_q   [NUM_CH];
  logic [2:0]        seg_flg [NUM_CH];
  logic [WIN_CW-1:0] win_cnt [NUM_CH];
  logic [2:0]        seg_vld [NUM_CH];

  logic [NUM_CH-1:0] rdy_mask;
  logic              pick_vld;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W:0]     scan_idx;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   inflight_ch;
  logic [TO_CW-1:0]  to_cnt;
  logic              res_sent;

  disp_st_t d_st, d_nxt;
  logic     start_nxt;
  logic     dispatch;
  logic     release_job;
  logic     timeout_hit;
  logic     res_take;

  always_comb begin
    rdy_mask  = '0;
    slot_busy = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      seg_vld[c]   = {sf_out_vld[c], sf_mid_vld[c], sf_inn_vld[c]};
      // a slot being overwritten this cycle must not be dispatched with stale data
      rdy_mask[c]  = (slot_st[c] == S_READY) && !pl_vld[c];
      slot_busy[c] = (slot_st[c] != S_EMPTY);
    end
  end

  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (scan_idx >= (CH_W+1)'(NUM_CH)) scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
      if (!pick_vld && rdy_mask[scan_idx[CH_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_ch  = scan_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    d_nxt       = d_st;
    start_nxt   = core_start;
    dispatch    = 1'b0;
    release_job = 1'b0;
    timeout_hit = 1'b0;
    case (d_st)
      D_IDLE: begin
        start_nxt = 1'b0;
        if (pick_vld) begin
          dispatch = 1'b1;
          d_nxt    = D_START;
        end
      end
      D_START: begin
        if (core_start && core_ready && core_done) begin
          start_nxt   = 1'b0;
          release_job = 1'b1;
          d_nxt       = D_IDLE;
        end else if (to_cnt <= TO_CW'(1)) begin
          start_nxt   = 1'b0;
          timeout_hit = 1'b1;
          release_job = 1'b1;
          d_nxt       = D_IDLE;
        end else if (core_start && core_ready) begin
          start_nxt = 1'b0;
          d_nxt     = D_WAIT;
        end else begin
          start_nxt = 1'b1;
        end
      end
      D_WAIT: begin
        if (core_done) begin
          release_job = 1'b1;
          d_nxt       = D_IDLE;
        end else if (to_cnt <= TO_CW'(1)) begin
          timeout_hit = 1'b1;
          release_job = 1'b1;
          d_nxt       = D_IDLE;
        end
      end
      default: d_nxt = D_IDLE;
    endcase
  end

  assign res_take = (d_st != D_IDLE) && core_result_vld && !res_sent;

  // window counter is loaded one below WINDOW so it hits 0 exactly WINDOW cycles after pl_vld
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        slot_st[c] <= S_EMPTY;
        pl_q[c]    <= '0;
        inn_q[c]   <= '0;
        mid_q[c]   <= '0;
        out_q[c]   <= '0;
        seg_flg[c] <= '0;
        win_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case (slot_st[c])
          S_EMPTY, S_COLLECT, S_READY: begin
            if (pl_vld[c]) begin
              pl_q[c]    <= pl_data[c*PL_W +: PL_W];
              inn_q[c]   <= sf_inn_vld[c] ? sf_inn_data[c*SF_W +: SF_W] : '0;
              mid_q[c]   <= sf_mid_vld[c] ? sf_mid_data[c*SF_W +: SF_W] : '0;
              out_q[c]   <= sf_out_vld[c] ? sf_out_data[c*SF_W +: SF_W] : '0;
              seg_flg[c] <= seg_vld[c];
              win_cnt[c] <= WIN_CW'(WINDOW - 1);
              slot_st[c] <= (&seg_vld[c] || WINDOW <= 1) ? S_READY : S_COLLECT;
            end else if (slot_st[c] == S_COLLECT) begin
              if (sf_inn_vld[c]) inn_q[c] <= sf_inn_data[c*SF_W +: SF_W];
              if (sf_mid_vld[c]) mid_q[c] <= sf_mid_data[c*SF_W +: SF_W];
              if (sf_out_vld[c]) out_q[c] <= sf_out_data[c*SF_W +: SF_W];
              seg_flg[c] <= seg_flg[c] | seg_vld[c];
              if (win_cnt[c] != '0) win_cnt[c] <= win_cnt[c] - WIN_CW'(1);
              if ((&(seg_flg[c] | seg_vld[c])) || (win_cnt[c] <= WIN_CW'(1)))
                slot_st[c] <= S_READY;
            end else if (slot_st[c] == S_READY && dispatch && pick_ch == CH_W'(c)) begin
              slot_st[c] <= S_INFLIGHT;
            end
          end
          S_INFLIGHT: begin
            if (release_job && inflight_ch == CH_W'(c)) slot_st[c] <= S_EMPTY;
          end
          default: slot_st[c] <= S_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      d_st           <= D_IDLE;
      core_start     <= 1'b0;
      core_pl        <= '0;
      core_sf_inn    <= '0;
      core_sf_mid    <= '0;
      core_sf_out    <= '0;
      core_is_C_side <= 1'b0;
      ptcalc2mtc     <= '0;
      ptcalc2mtc_vld <= 1'b0;
      ptcalc2mtc_ch  <= '0;
      err_overflow   <= 1'b0;
      err_timeout    <= 1'b0;
      rr_ptr         <= '0;
      inflight_ch    <= '0;
      to_cnt         <= '0;
      res_sent       <= 1'b0;
    end else begin
      d_st           <= d_nxt;
      core_start     <= start_nxt;
      core_is_C_side <= is_C_side;
      err_overflow   <= |(pl_vld & slot_busy);
      err_timeout    <= timeout_hit;
      ptcalc2mtc_vld <= res_take;
      if (res_take) begin
        ptcalc2mtc    <= core_result;
        ptcalc2mtc_ch <= inflight_ch;
        res_sent      <= 1'b1;
      end
      if (dispatch) begin
        core_pl     <= pl_q[pick_ch];
        core_sf_inn <= inn_q[pick_ch];
        core_sf_mid <= mid_q[pick_ch];
        core_sf_out <= out_q[pick_ch];
        inflight_ch <= pick_ch;
        rr_ptr      <= (pick_ch == CH_W'(NUM_CH - 1)) ? '0 : pick_ch + CH_W'(1);
        to_cnt      <= TO_CW'(TIMEOUT - 1);
        res_sent    <= 1'b0;
      end else if (d_st != D_IDLE && to_cnt != '0) begin
        to_cnt <= to_cnt - TO_CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ptcalc_dispatch.sv
// Directed bench for ptcalc_dispatch with a small behavioural core that echoes core_pl
// as its result a programmable number of cycles after the start handshake.
module tb_ptcalc_dispatch;

  localparam int NUM_CH = 3;
  localparam int PL_W   = 32;
  localparam int SF_W   = 24;
  localparam int OUT_W  = 16;
  localparam int CH_W   = 2;

  logic                   ap_clk;
  logic                   ap_rst_n;
  logic [NUM_CH*PL_W-1:0] pl_data;
  logic [NUM_CH-1:0]      pl_vld;
  logic [NUM_CH*SF_W-1:0] sf_inn_data, sf_mid_data, sf_out_data;
  logic [NUM_CH-1:0]      sf_inn_vld, sf_mid_vld, sf_out_vld;
  logic                   is_C_side;
  logic                   core_start;
  logic [PL_W-1:0]        core_pl;
  logic [SF_W-1:0]        core_sf_inn, core_sf_mid, core_sf_out;
  logic                   core_is_C_side;
  logic                   core_ready, core_done, core_result_vld;
  logic [OUT_W-1:0]       core_result;
  logic [OUT_W-1:0]       ptcalc2mtc;
  logic                   ptcalc2mtc_vld;
  logic [CH_W-1:0]        ptcalc2mtc_ch;
  logic [NUM_CH-1:0]      slot_busy;
  logic                   err_overflow, err_timeout;

  ptcalc_dispatch #(
    .NUM_CH(NUM_CH), .PL_W(PL_W), .SF_W(SF_W), .OUT_W(OUT_W), .CH_W(CH_W),
    .WINDOW(32), .TIMEOUT(128)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .pl_data(pl_data), .pl_vld(pl_vld),
    .sf_inn_data(sf_inn_data), .sf_mid_data(sf_mid_data), .sf_out_data(sf_out_data),
    .sf_inn_vld(sf_inn_vld), .sf_mid_vld(sf_mid_vld), .sf_out_vld(sf_out_vld),
    .is_C_side(is_C_side),
    .core_start(core_start), .core_pl(core_pl),
    .core_sf_inn(core_sf_inn), .core_sf_mid(core_sf_mid), .core_sf_out(core_sf_out),
    .core_is_C_side(core_is_C_side),
    .core_ready(core_ready), .core_done(core_done),
    .core_result(core_result), .core_result_vld(core_result_vld),
    .ptcalc2mtc(ptcalc2mtc), .ptcalc2mtc_vld(ptcalc2mtc_vld), .ptcalc2mtc_ch(ptcalc2mtc_ch),
    .slot_busy(slot_busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;

  int core_lat  = 4;
  bit core_mute = 1'b0;
  int core_pend = 0;
  logic [OUT_W-1:0] core_resp;

  logic [CH_W-1:0]  res_ch_q[$];
  logic [OUT_W-1:0] res_dat_q[$];
  int               res_cyc_q[$];
  int               start_cyc_q[$];
  logic [PL_W-1:0]  disp_pl_q[$];
  logic [SF_W-1:0]  disp_inn_q[$], disp_mid_q[$], disp_out_q[$];
  logic             disp_side_q[$];
  int               ovf_cnt = 0;
  int               tmo_cnt = 0;
  int               tmo_cyc = 0;
  logic             start_prev = 1'b0;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    forever begin
      @(posedge ap_clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: observes outputs on the falling edge
  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        if (ptcalc2mtc_vld) begin
          res_ch_q.push_back(ptcalc2mtc_ch);
          res_dat_q.push_back(ptcalc2mtc);
          res_cyc_q.push_back(cyc);
        end
        if (err_overflow) ovf_cnt++;
        if (err_timeout) begin
          tmo_cnt++;
          tmo_cyc = cyc;
        end
        if (core_start && !start_prev) start_cyc_q.push_back(cyc);
      end
      start_prev = core_start;
    end
  end

  // behavioural core: handshake seen at negedge, answer core_lat cycles later
  initial begin
    core_ready = 1'b1; core_done = 1'b0; core_result_vld = 1'b0; core_result = '0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && core_start && core_ready) begin
        disp_pl_q.push_back(core_pl);
        disp_inn_q.push_back(core_sf_inn);
        disp_mid_q.push_back(core_sf_mid);
        disp_out_q.push_back(core_sf_out);
        disp_side_q.push_back(core_is_C_side);
        core_resp = core_pl[OUT_W-1:0];
        if (!core_mute) core_pend = core_lat;
      end
      @(posedge ap_clk); #1;
      core_done = 1'b0; core_result_vld = 1'b0;
      if (core_pend > 0) begin
        core_pend--;
        if (core_pend == 0) begin
          core_done = 1'b1; core_result_vld = 1'b1; core_result = core_resp;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    res_ch_q.delete(); res_dat_q.delete(); res_cyc_q.delete(); start_cyc_q.delete();
    disp_pl_q.delete(); disp_inn_q.delete(); disp_mid_q.delete(); disp_out_q.delete();
    disp_side_q.delete();
    ovf_cnt = 0; tmo_cnt = 0; tmo_cyc = 0;
  endtask

  task automatic set_job(input int c, input logic [PL_W-1:0] pl,
                         input logic [SF_W-1:0] si, input logic [SF_W-1:0] sm,
                         input logic [SF_W-1:0] so);
    pl_data[c*PL_W +: PL_W]     = pl;
    sf_inn_data[c*SF_W +: SF_W] = si;
    sf_mid_data[c*SF_W +: SF_W] = sm;
    sf_out_data[c*SF_W +: SF_W] = so;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] pm, input logic [NUM_CH-1:0] im,
                       input logic [NUM_CH-1:0] mm, input logic [NUM_CH-1:0] om);
    pl_vld = pm; sf_inn_vld = im; sf_mid_vld = mm; sf_out_vld = om;
    @(posedge ap_clk); #1;
    pl_vld = '0; sf_inn_vld = '0; sf_mid_vld = '0; sf_out_vld = '0;
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (res_ch_q.size() < n && k < budget) begin
      @(posedge ap_clk); #1;
      k++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((slot_busy != '0 || core_start) && k < budget) begin
      @(posedge ap_clk); #1;
      k++;
    end
    chk("idle_reached", {63'd0, (slot_busy != '0 || core_start)}, 64'd0);
    repeat (4) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    ap_rst_n = 1'b0; is_C_side = 1'b1;
    pl_data = '0; pl_vld = '0;
    sf_inn_data = '0; sf_mid_data = '0; sf_out_data = '0;
    sf_inn_vld = '0; sf_mid_vld = '0; sf_out_vld = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_busy", slot_busy, 0);
    chk("rst_start", core_start, 0);
    chk("rst_side", core_is_C_side, 0);
    chk("rst_vld", ptcalc2mtc_vld, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // round robin from pointer 0
    clear_logs();
    for (int c = 0; c < NUM_CH; c++)
      set_job(c, 32'h100 + c, 24'h10 + c, 24'h20 + c, 24'h30 + c);
    t0 = cyc;
    pulse(3'b111, 3'b111, 3'b111, 3'b111);
    wait_res(3, 100);
    wait_idle(50);
    chk("rr_cnt", res_ch_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("rr_ch", res_ch_q[i], i);
      chk("rr_dat", res_dat_q[i], 16'h100 + i);
    end

    // single job on ch1, best-case latency
    clear_logs();
    set_job(1, 32'h2A, 24'h111111, 24'h222222, 24'h333333);
    t0 = cyc;
    pulse(3'b010, 3'b010, 3'b010, 3'b010);
    chk("s1_busy", slot_busy, 3'b010);
    wait_res(1, 50);
    wait_idle(50);
    chk("s1_cnt", res_ch_q.size(), 1);
    chk("s1_ch", res_ch_q[0], 1);
    chk("s1_dat", res_dat_q[0], 16'h2A);
    chk("s1_start_lat", start_cyc_q[0] - t0, 3);
    chk("s1_res_lat", res_cyc_q[0] - t0, 8);
    chk("s1_inn", disp_inn_q[0], 24'h111111);
    chk("s1_mid", disp_mid_q[0], 24'h222222);
    chk("s1_out", disp_out_q[0], 24'h333333);
    chk("s1_side", disp_side_q[0], 1);
    chk("s1_free", slot_busy, 0);

    // window expiry with inner segment only
    clear_logs();
    set_job(0, 32'h55, 24'hABCDEF, 24'h0F0F0F, 24'h0F0F0F);
    t0 = cyc;
    pulse(3'b001, 3'b001, 3'b000, 3'b000);
    wait_res(1, 100);
    wait_idle(50);
    chk("win_start", start_cyc_q[0] - t0, 34);
    chk("win_inn", disp_inn_q[0], 24'hABCDEF);
    chk("win_mid", disp_mid_q[0], 0);
    chk("win_out", disp_out_q[0], 0);
    chk("win_ch", res_ch_q[0], 0);
    chk("win_dat", res_dat_q[0], 16'h55);

    // overflow: ch2 restarted while collecting
    clear_logs();
    set_job(2, 32'hAAA, 24'h1, 24'h2, 24'h3);
    t0 = cyc;
    pulse(3'b100, 3'b100, 3'b000, 3'b000);
    set_job(2, 32'hBBB, 24'h4, 24'h5, 24'h6);
    pulse(3'b100, 3'b100, 3'b100, 3'b100);
    wait_res(1, 60);
    wait_idle(50);
    chk("ovf_pulses", ovf_cnt, 1);
    chk("ovf_ndisp", disp_pl_q.size(), 1);
    chk("ovf_pl", disp_pl_q[0], 32'hBBB);
    chk("ovf_inn", disp_inn_q[0], 24'h4);
    chk("ovf_ch", res_ch_q[0], 2);
    chk("ovf_dat", res_dat_q[0], 16'hBBB);

    // timeout on ch0, then ch1 dispatched
    clear_logs();
    core_mute = 1'b1;
    set_job(0, 32'hC0, 24'h7, 24'h8, 24'h9);
    set_job(1, 32'hC1, 24'hA, 24'hB, 24'hC);
    t0 = cyc;
    pulse(3'b011, 3'b011, 3'b011, 3'b011);
    begin
      int k = 0;
      while (tmo_cnt == 0 && k < 200) begin
        @(posedge ap_clk); #1;
        k++;
      end
    end
    core_mute = 1'b0;
    chk("to_pulses", tmo_cnt, 1);
    chk("to_cycle", tmo_cyc - t0, 129);
    chk("to_nores", res_ch_q.size(), 0);
    chk("to_free", slot_busy, 3'b010);
    wait_res(1, 60);
    wait_idle(50);
    chk("to_next_start", start_cyc_q[1] - t0, 131);
    chk("to_next_ch", res_ch_q[0], 1);
    chk("to_next_dat", res_dat_q[0], 16'hC1);
    chk("to_single", tmo_cnt, 1);

    // asynchronous reset while the core is working
    clear_logs();
    core_lat = 20;
    set_job(1, 32'hD1, 24'hD, 24'hE, 24'hF);
    pulse(3'b010, 3'b010, 3'b010, 3'b010);
    begin
      int k = 0;
      while (start_cyc_q.size() == 0 && k < 20) begin
        @(posedge ap_clk); #1;
        k++;
      end
    end
    repeat (4) @(posedge ap_clk);
    #1;
    chk("pre_rst_pl", core_pl, 32'hD1);
    @(negedge ap_clk); #2;
    ap_rst_n = 1'b0;
    core_pend = 0;
    #1;
    chk("arst_start", core_start, 0);
    chk("arst_pl", core_pl, 0);
    chk("arst_inn", core_sf_inn, 0);
    chk("arst_side", core_is_C_side, 0);
    chk("arst_busy", slot_busy, 0);
    chk("arst_res", ptcalc2mtc, 0);
    chk("arst_ch", ptcalc2mtc_ch, 0);
    chk("arst_err", {err_overflow, err_timeout, ptcalc2mtc_vld}, 0);
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    clear_logs();
    core_lat = 4;
    set_job(2, 32'hE2, 24'h21, 24'h22, 24'h23);
    pulse(3'b100, 3'b100, 3'b100, 3'b100);
    wait_res(1, 50);
    wait_idle(50);
    repeat (20) @(posedge ap_clk);
    #1;
    chk("post_cnt", res_ch_q.size(), 1);
    chk("post_ch", res_ch_q[0], 2);
    chk("post_dat", res_dat_q[0], 16'hE2);
    chk("post_errs", ovf_cnt + tmo_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
